// File: rtl/ips2l_pcie_dma_bar1_wr_unpack_if.sv
// rtl/ips2l_pcie_dma_bar1_wr_unpack_if.sv - BAR1 line-write input bus and DW register-write output bus
interface ips2l_pcie_dma_bar1_wr_unpack_if #(
  parameter int ADDR_WIDTH = 9
);
  logic                  i_bar1_wr_en;
  logic [ADDR_WIDTH-1:0] i_bar1_wr_addr;
  logic [127:0]          i_bar1_wr_data;
  logic [15:0]           i_bar1_wr_byte_en;
  logic                  o_reg_wr_vld;
  logic                  i_reg_wr_rdy;
  logic [ADDR_WIDTH+1:0] o_reg_wr_addr;
  logic [31:0]           o_reg_wr_data;
  logic [3:0]            o_reg_wr_be;

  modport slave (
    input  i_bar1_wr_en, i_bar1_wr_addr, i_bar1_wr_data, i_bar1_wr_byte_en, i_reg_wr_rdy,
    output o_reg_wr_vld, o_reg_wr_addr, o_reg_wr_data, o_reg_wr_be
  );

  modport master (
    output i_bar1_wr_en, i_bar1_wr_addr, i_bar1_wr_data, i_bar1_wr_byte_en, i_reg_wr_rdy,
    input  o_reg_wr_vld, o_reg_wr_addr, o_reg_wr_data, o_reg_wr_be
  );
endinterface

// File: rtl/ips2l_pcie_dma_bar1_wr_unpack.sv
// rtl/ips2l_pcie_dma_bar1_wr_unpack.sv - buffers 128-bit BAR1 write beats and unpacks them into serial DW writes
module ips2l_pcie_dma_bar1_wr_unpack #(
  parameter int ADDR_WIDTH      = 9,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  ips2l_pcie_dma_bar1_wr_unpack_if.slave         bus,
  output logic                                   o_fifo_full,
  output logic [15:0]                            o_ovf_cnt,
  input  logic                                   i_ovf_clr
);
  localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int ENTRY_W    = ADDR_WIDTH + 128 + 16;
  localparam logic [FIFO_DEPTH_LOG2:0] DEPTH_CNT = (FIFO_DEPTH_LOG2 + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

  state_t state, state_next;

  logic [ENTRY_W-1:0]         mem [FIFO_DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   count, count_next;
  logic [ENTRY_W-1:0]         rd_entry;
  logic                       beat_live, push, pop, drop;

  logic [ADDR_WIDTH-1:0] hold_addr;
  logic [127:0]          hold_data;
  logic [15:0]           hold_be;
  logic [3:0]            dw_mask, dw_onehot, mask_rest;
  logic [1:0]            dw_idx;
  logic                  accept;

  // Full comes from the registered flag, so a drop can coincide with a pop.
  assign beat_live = bus.i_bar1_wr_en & (|bus.i_bar1_wr_byte_en);
  assign push      = beat_live & ~o_fifo_full;
  assign drop      = beat_live & o_fifo_full;
  assign pop       = (state == IDLE) && (count != '0);

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.i_bar1_wr_addr, bus.i_bar1_wr_data, bus.i_bar1_wr_byte_en};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      o_fifo_full <= 1'b0;
      rd_entry    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        rd_entry <= mem[rd_ptr];
      end
      count       <= count_next;
      o_fifo_full <= (count_next == DEPTH_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || i_ovf_clr) o_ovf_cnt <= '0;
    else if (drop && o_ovf_cnt != 16'hFFFF) o_ovf_cnt <= o_ovf_cnt + 16'd1;
  end

  always_comb begin
    dw_idx = 2'd0;
    for (int n = 3; n >= 0; n--) begin
      if (dw_mask[n]) dw_idx = 2'(n);
    end
  end

  assign dw_onehot = 4'b0001 << dw_idx;
  assign mask_rest = dw_mask & ~dw_onehot;
  assign accept    = (state == EMIT) && bus.i_reg_wr_rdy;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (count != '0) state_next = LOAD;
      LOAD:    state_next = EMIT;
      EMIT:    if (accept && mask_rest == 4'b0000) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_addr <= '0;
      hold_data <= '0;
      hold_be   <= '0;
      dw_mask   <= '0;
    end else if (state == LOAD) begin
      hold_addr <= rd_entry[ENTRY_W-1 -: ADDR_WIDTH];
      hold_data <= rd_entry[143:16];
      hold_be   <= rd_entry[15:0];
      for (int n = 0; n < 4; n++) dw_mask[n] <= |rd_entry[4*n +: 4];
    end else if (accept) begin
      dw_mask <= mask_rest;
    end
  end

  always_comb begin
    bus.o_reg_wr_vld  = 1'b0;
    bus.o_reg_wr_addr = '0;
    bus.o_reg_wr_data = '0;
    bus.o_reg_wr_be   = '0;
    if (state == EMIT) begin
      bus.o_reg_wr_vld  = 1'b1;
      bus.o_reg_wr_addr = {hold_addr, dw_idx};
      bus.o_reg_wr_data = hold_data[{dw_idx, 5'b00000} +: 32];
      bus.o_reg_wr_be   = hold_be[{dw_idx, 2'b00} +: 4];
    end
  end
endmodule

// File: tb/tb_ips2l_pcie_dma_bar1_wr_unpack.sv
// tb/tb_ips2l_pcie_dma_bar1_wr_unpack.sv - directed self-checking bench for the BAR1 write unpacker
module tb_ips2l_pcie_dma_bar1_wr_unpack;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ovf_clr = 1'b0;
  logic        fifo_full;
  logic [15:0] ovf_cnt;
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [46:0] wq [$];
  int          wc [$];

  ips2l_pcie_dma_bar1_wr_unpack_if #(.ADDR_WIDTH(9)) bus ();

  ips2l_pcie_dma_bar1_wr_unpack #(.ADDR_WIDTH(9), .FIFO_DEPTH_LOG2(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_fifo_full (fifo_full),
    .o_ovf_cnt   (ovf_cnt),
    .i_ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Log each accepted DW write; inputs only change just after posedge.
  always @(negedge clk) begin
    if (rst_n && bus.o_reg_wr_vld && bus.i_reg_wr_rdy) begin
      wq.push_back({bus.o_reg_wr_addr, bus.o_reg_wr_data, bus.o_reg_wr_be});
      wc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [8:0] a, input logic [127:0] d, input logic [15:0] be);
    bus.i_bar1_wr_en      = 1'b1;
    bus.i_bar1_wr_addr    = a;
    bus.i_bar1_wr_data    = d;
    bus.i_bar1_wr_byte_en = be;
    tick();
    bus.i_bar1_wr_en      = 1'b0;
  endtask

  task automatic wait_vld(input string tag);
    int n = 0;
    while (!bus.o_reg_wr_vld && n < 50) begin
      tick();
      n++;
    end
    check(tag, 64'(bus.o_reg_wr_vld), 64'd1);
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [10:0] a,
                          input logic [31:0] d, input logic [3:0] be);
    if (idx < wq.size()) check(tag, 64'(wq[idx]), 64'({a, d, be}));
    else                 check({tag, "_missing"}, 64'(wq.size()), 64'(idx + 1));
  endtask

  task automatic check_out(input string tag, input logic v, input logic [10:0] a,
                           input logic [31:0] d, input logic [3:0] be);
    check(tag, 64'({bus.o_reg_wr_vld, bus.o_reg_wr_addr, bus.o_reg_wr_data, bus.o_reg_wr_be}),
          64'({v, a, d, be}));
  endtask

  initial begin
    bus.i_bar1_wr_en      = 1'b0;
    bus.i_bar1_wr_addr    = '0;
    bus.i_bar1_wr_data    = '0;
    bus.i_bar1_wr_byte_en = '0;
    bus.i_reg_wr_rdy      = 1'b0;
    tick(2);
    rst_n = 1'b1;

    check_out("reset_outputs", 1'b0, 11'h0, 32'h0, 4'h0);
    check("reset_full", 64'(fifo_full), 64'd0);
    check("reset_ovf", 64'(ovf_cnt), 64'd0);

    // 1: single DW, latency
    bus.i_reg_wr_rdy = 1'b1;
    send(9'h005, 128'h3333_3333_2222_2222_A5A5_0001_1111_1111, 16'h00F0);
    check("t1_cycle1_vld", 64'(bus.o_reg_wr_vld), 64'd0);
    tick();
    check("t1_cycle2_vld", 64'(bus.o_reg_wr_vld), 64'd0);
    tick();
    check_out("t1_cycle3_out", 1'b1, 11'h015, 32'hA5A5_0001, 4'hF);
    tick();
    check("t1_after_vld", 64'(bus.o_reg_wr_vld), 64'd0);
    tick(6);
    check("t1_count", 64'(wq.size()), 64'd1);
    check_wr("t1_wr", 0, 11'h015, 32'hA5A5_0001, 4'hF);

    // 2: full line, sparse line, zero byte enables
    wq.delete(); wc.delete();
    send(9'h003, 128'h4444_4444_3333_3333_2222_2222_1111_1111, 16'hFFFF);
    send(9'h007, 128'hDDDD_0003_CCCC_0002_BBBB_0001_AAAA_0000, 16'h0F30);
    send(9'h01A, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 16'h0000);
    tick(20);
    check("t2_count", 64'(wq.size()), 64'd6);
    check_wr("t2_dw0", 0, 11'h00C, 32'h1111_1111, 4'hF);
    check_wr("t2_dw1", 1, 11'h00D, 32'h2222_2222, 4'hF);
    check_wr("t2_dw2", 2, 11'h00E, 32'h3333_3333, 4'hF);
    check_wr("t2_dw3", 3, 11'h00F, 32'h4444_4444, 4'hF);
    check_wr("t2_sparse_dw1", 4, 11'h01D, 32'hBBBB_0001, 4'h3);
    check_wr("t2_sparse_dw2", 5, 11'h01E, 32'hCCCC_0002, 4'hF);
    if (wc.size() == 6) begin
      check("t2_back_to_back", 64'(wc[3] - wc[0]), 64'd3);
      check("t2_entry_gap", 64'(wc[4] - wc[3]), 64'd3);
      check("t2_sparse_gap", 64'(wc[5] - wc[4]), 64'd1);
    end else check("t2_stamp_count", 64'(wc.size()), 64'd6);
    check("t2_ovf", 64'(ovf_cnt), 64'd0);

    // 3: backpressure
    wq.delete(); wc.delete();
    bus.i_reg_wr_rdy = 1'b0;
    send(9'h010, 128'h5000_0003_5000_0002_5000_0001_5000_0000, 16'hFFFF);
    wait_vld("t3_wait_vld");
    check_out("t3_dw0", 1'b1, 11'h040, 32'h5000_0000, 4'hF);
    bus.i_reg_wr_rdy = 1'b1;
    tick();
    bus.i_reg_wr_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_out($sformatf("t3_hold%0d", i), 1'b1, 11'h041, 32'h5000_0001, 4'hF);
      tick();
    end
    bus.i_reg_wr_rdy = 1'b1;
    tick();
    check_out("t3_next_dw2", 1'b1, 11'h042, 32'h5000_0002, 4'hF);
    tick();
    check_out("t3_next_dw3", 1'b1, 11'h043, 32'h5000_0003, 4'hF);
    tick();
    check("t3_done", 64'(bus.o_reg_wr_vld), 64'd0);
    check("t3_count", 64'(wq.size()), 64'd4);
    check_wr("t3_wr_dw1", 1, 11'h041, 32'h5000_0001, 4'hF);

    // 4: overflow; a blocker line parks the FSM so all 8 FIFO slots fill from the burst
    wq.delete(); wc.delete();
    bus.i_reg_wr_rdy = 1'b0;
    send(9'h1F1, 128'h0000_0000_0000_0000_0000_0000_B10C_0000, 16'h000F);
    wait_vld("t4_wait_blocker");
    for (int i = 0; i < 10; i++) begin
      send(9'(i), {96'h0, 32'hC0DE_0000 | 32'(i)}, 16'h000F);
      if (i == 6) check("t4_not_full_7", 64'(fifo_full), 64'd0);
      if (i == 7) check("t4_full_8", 64'(fifo_full), 64'd1);
    end
    check("t4_ovf", 64'(ovf_cnt), 64'd2);
    bus.i_reg_wr_rdy = 1'b1;
    tick();
    check("t4_full_before_pop", 64'(fifo_full), 64'd1);
    tick();
    check("t4_full_after_pop", 64'(fifo_full), 64'd0);
    tick(40);
    check("t4_count", 64'(wq.size()), 64'd9);
    check_wr("t4_blocker", 0, 11'h7C4, 32'hB10C_0000, 4'hF);
    for (int i = 0; i < 8; i++)
      check_wr($sformatf("t4_wr%0d", i), i + 1, 11'(i << 2), 32'hC0DE_0000 | 32'(i), 4'hF);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t4_ovf_clr", 64'(ovf_cnt), 64'd0);

    // 5: clear vs drop, saturation
    bus.i_reg_wr_rdy = 1'b0;
    send(9'h100, 128'h1, 16'h000F);
    wait_vld("t5_wait_blocker");
    for (int i = 0; i < 8; i++) send(9'(i), 128'h2, 16'h000F);
    check("t5_full", 64'(fifo_full), 64'd1);
    send(9'h050, 128'h3, 16'h000F);
    check("t5_one_drop", 64'(ovf_cnt), 64'd1);
    ovf_clr = 1'b1;
    send(9'h051, 128'h3, 16'h000F);
    ovf_clr = 1'b0;
    check("t5_clr_wins", 64'(ovf_cnt), 64'd0);
    bus.i_bar1_wr_en      = 1'b1;
    bus.i_bar1_wr_byte_en = 16'h0F00;
    tick(65534);
    check("t5_ovf_fffe", 64'(ovf_cnt), 64'hFFFE);
    tick();
    check("t5_ovf_ffff", 64'(ovf_cnt), 64'hFFFF);
    tick(3);
    check("t5_ovf_sat", 64'(ovf_cnt), 64'hFFFF);
    bus.i_bar1_wr_en = 1'b0;

    // 6: reset mid-EMIT
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    send(9'h02A, 128'h6000_0003_6000_0002_6000_0001_6000_0000, 16'hFFFF);
    wait_vld("t6_wait_vld");
    bus.i_reg_wr_rdy = 1'b1;
    tick();
    bus.i_reg_wr_rdy = 1'b0;
    check_out("t6_pending_dw1", 1'b1, 11'h0A9, 32'h6000_0001, 4'hF);
    for (int i = 0; i < 9; i++) send(9'(i), 128'h7, 16'h000F);
    check("t6_pre_full", 64'(fifo_full), 64'd1);
    check("t6_pre_ovf", 64'(ovf_cnt), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6_rst_vld", 64'(bus.o_reg_wr_vld), 64'd0);
    check("t6_rst_full", 64'(fifo_full), 64'd0);
    check("t6_rst_ovf", 64'(ovf_cnt), 64'd0);
    wq.delete(); wc.delete();
    bus.i_reg_wr_rdy = 1'b1;
    send(9'h033, 128'hCAFE_F00D_0000_0000_0000_0000_0000_0000, 16'hF000);
    check("t6_cycle1_vld", 64'(bus.o_reg_wr_vld), 64'd0);
    tick();
    check("t6_cycle2_vld", 64'(bus.o_reg_wr_vld), 64'd0);
    tick();
    check_out("t6_cycle3_out", 1'b1, 11'h0CF, 32'hCAFE_F00D, 4'hF);
    tick(20);
    check("t6_no_stale", 64'(wq.size()), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
